mmio_run_ctrl: RTL and testbench
================================

MMIO_RUN_CTRL -- requirements
Module: mmio_run_ctrl

Interface
REQ-001 SHALL take parameter ADDR_WIDTH, default 64: width of the configured DMA byte addresses.
REQ-002 SHALL take parameter SIZE_WIDTH, default 32: width of num_samples and collect_cycles.
REQ-003 SHALL take parameter POLL_GAP, default 16: idle cycles between consecutive done polls (legal range 1..255).
REQ-004 SHALL have the following ports, one per line: name, direction, width, meaning.
- clk  in  1  sole clock.
- rst  in  1  asynchronous, active-low reset (asserted at 0).
- start  in  1  single-cycle launch request.
- cfg_rd_addr  in  ADDR_WIDTH  DMA read address.
- cfg_wr_addr  in  ADDR_WIDTH  DMA write address.
- cfg_num_samples  in  SIZE_WIDTH  cache lines to transfer.
- cfg_collect_cycles  in  SIZE_WIDTH  collection cycle count.
- cfg_switcher_en  in  1  switcher enable value.
- cfg_timeout  in  32  poll timeout in cycles; 0 = none.
- mmio_wr_en  out  1  MMIO write strobe.
- mmio_wr_addr  out  16  MMIO write word address.
- mmio_wr_data  out  64  MMIO write data.
- mmio_rd_en  out  1  MMIO read strobe.
- mmio_rd_addr  out  16  MMIO read word address.
- mmio_rd_data  in  64  read data, valid exactly 1 cycle after mmio_rd_en.
- busy  out  1  sequence in progress.
- run_done  out  1  one-cycle pulse: target reported done.
- err_cfg  out  1  sticky: readback mismatch.
- err_timeout  out  1  sticky: poll timeout.

Function
REQ-005 SHALL, in IDLE, accept start by latching all cfg_* inputs, clearing err_cfg and err_timeout, and asserting busy the next cycle.
REQ-006 SHALL ignore start while busy=1.
REQ-007 SHALL run the FSM IDLE -> WR_CFG -> RD_ISSUE -> RD_CHK -> GO -> POLL_WAIT -> POLL_RD -> POLL_CHK -> IDLE.
REQ-008 In WR_CFG, SHALL issue one write per cycle in this order, with zero-extended data: 0x0052 rd_addr, 0x0054 wr_addr, 0x0056 num_samples, 0x0058 collect_cycles, 0x0070 switcher_en.
REQ-009 In RD_ISSUE/RD_CHK, SHALL read back 0x0052, 0x0054, 0x0056, 0x0058 and 0x0070 in turn (one read, then one compare cycle each) and compare all 64 bits of data against the zero-extended latched value.
REQ-010 On any readback mismatch, SHALL set err_cfg, issue no go write, and return to IDLE.
REQ-011 In GO, SHALL issue exactly one write to 0x0050 with data 1, then clear the timeout counter.
REQ-012 In POLL_WAIT, SHALL idle for POLL_GAP cycles, then issue one read of 0x0060 in POLL_RD and sample bit 0 in POLL_CHK.
REQ-013 When the sampled bit is 1, SHALL pulse run_done for one cycle and return to IDLE; when it is 0, SHALL return to POLL_WAIT.
REQ-014 SHALL count cycles from the cycle after the go write; when cfg_timeout != 0 and the count reaches cfg_timeout before done is seen, SHALL set err_timeout and return to IDLE.
REQ-015 When done is seen on the same cycle the timeout count is reached, SHALL give done priority (run_done=1, err_timeout=0).
REQ-016 SHALL never assert mmio_wr_en and mmio_rd_en in the same cycle, and SHALL drive both the MMIO address and data to 0 whenever the matching strobe is 0.
REQ-017 SHALL hold busy=1 from the cycle after start is accepted until the cycle the FSM re-enters IDLE.

Reset
REQ-018 While rst=0, SHALL force the FSM to IDLE, clear all counters and latched configuration, and drive every output to 0.
REQ-019 When reset is asserted mid-sequence, SHALL abort with no further MMIO strobes, and on release SHALL wait in IDLE for a new start.

Structure
REQ-020 SHALL take the register word addresses (0x0050, 0x0052, 0x0054, 0x0056, 0x0058, 0x0060, 0x0070) and the FSM state enum from shared package mmio_run_pkg.
REQ-021 SHALL be a single module with no sub-modules; the timeout counter and poll-gap counter SHALL be inline.

Verification
REQ-022 Nominal run against a memory_map responder: cfg_rd_addr=0x1000, cfg_wr_addr=0x2000, num_samples=8, collect_cycles=100, switcher_en=1; done asserted after 200 cycles -> exactly 5 writes in the REQ-008 order, 5 readbacks, one go write, then run_done pulses once and busy falls.
REQ-023 Readback fault: responder returns 0x0000 for 0x0054 -> err_cfg=1, no write to 0x0050, busy falls.
REQ-024 Timeout: cfg_timeout=50, done never asserted -> err_timeout=1 within 50+POLL_GAP+2 cycles of the go write, no run_done.
REQ-025 Simultaneous events: done first sampled on the cycle the timeout count is reached -> run_done=1, err_timeout=0. Separately, start pulsed while busy -> no restart and latched configuration unchanged.
REQ-026 Mid-run reset: rst driven to 0 during POLL_WAIT -> all outputs 0 the same cycle and no strobes after release; a new start then completes normally.

Source files
------------

// File: rtl/mmio_run_pkg.sv
// Shared register map and FSM encoding
// for the MMIO run-control sequencer.
package mmio_run_pkg;

  localparam logic [15:0] REG_GO      = 16'h0050;
  localparam logic [15:0] REG_RD_ADDR = 16'h0052;
  localparam logic [15:0] REG_WR_ADDR = 16'h0054;
  localparam logic [15:0] REG_NUM     = 16'h0056;
  localparam logic [15:0] REG_COLLECT = 16'h0058;
  localparam logic [15:0] REG_STATUS  = 16'h0060;
  localparam logic [15:0] REG_SWITCH  = 16'h0070;

  localparam logic [2:0] CFG_LAST = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_CFG,
    ST_RD_ISSUE,
    ST_RD_CHK,
    ST_GO,
    ST_POLL_WAIT,
    ST_POLL_RD,
    ST_POLL_CHK
  } run_state_e;

  // Word address of the idx-th config register.
  function automatic logic [15:0] cfg_reg_addr(
    input logic [2:0] idx
  );
    logic [15:0] a;
    case (idx)
      3'd0:    a = REG_RD_ADDR;
      3'd1:    a = REG_WR_ADDR;
      3'd2:    a = REG_NUM;
      3'd3:    a = REG_COLLECT;
      3'd4:    a = REG_SWITCH;
      default: a = 16'h0000;
    endcase
    return a;
  endfunction

endpackage

// File: rtl/mmio_run_ctrl.sv
// Writes a run config over MMIO, verifies it,
// launches the target and polls for done.
module mmio_run_ctrl
  import mmio_run_pkg::*;
#(
  parameter int ADDR_WIDTH = 64,
  parameter int SIZE_WIDTH = 32,
  parameter int POLL_GAP   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] cfg_rd_addr,
  input  logic [ADDR_WIDTH-1:0] cfg_wr_addr,
  input  logic [SIZE_WIDTH-1:0] cfg_num_samples,
  input  logic [SIZE_WIDTH-1:0] cfg_collect_cycles,
  input  logic                  cfg_switcher_en,
  input  logic [31:0]           cfg_timeout,
  output logic                  mmio_wr_en,
  output logic [15:0]           mmio_wr_addr,
  output logic [63:0]           mmio_wr_data,
  output logic                  mmio_rd_en,
  output logic [15:0]           mmio_rd_addr,
  input  logic [63:0]           mmio_rd_data,
  output logic                  busy,
  output logic                  run_done,
  output logic                  err_cfg,
  output logic                  err_timeout
);

  localparam logic [7:0] GAP_LAST = 8'(POLL_GAP - 1);

  run_state_e state_q, state_d;

  logic [2:0]            idx_q, idx_d;
  logic [7:0]            gap_q, gap_d;
  logic [31:0]           tmo_q, tmo_d;
  logic [ADDR_WIDTH-1:0] rd_q, wr_q;
  logic [SIZE_WIDTH-1:0] ns_q, cc_q;
  logic                  sw_q;
  logic [31:0]           lim_q;
  logic                  ecfg_q, ecfg_d;
  logic                  etmo_q, etmo_d;
  logic                  done_q, done_d;
  logic                  latch;
  logic [63:0]           cfg_val;
  logic                  tmo_hit;

  always_comb begin
    cfg_val = '0;
    case (idx_q)
      3'd0:    cfg_val = 64'(rd_q);
      3'd1:    cfg_val = 64'(wr_q);
      3'd2:    cfg_val = 64'(ns_q);
      3'd3:    cfg_val = 64'(cc_q);
      3'd4:    cfg_val = 64'(sw_q);
      default: cfg_val = '0;
    endcase
  end

  // tmo_q + 1 is the number of cycles elapsed since the go write.
  assign tmo_hit = (lim_q != 32'd0) &&
                   (tmo_q + 32'd1 == lim_q);

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    gap_d        = gap_q;
    tmo_d        = tmo_q;
    ecfg_d       = ecfg_q;
    etmo_d       = etmo_q;
    done_d       = 1'b0;
    latch        = 1'b0;
    mmio_wr_en   = 1'b0;
    mmio_wr_addr = '0;
    mmio_wr_data = '0;
    mmio_rd_en   = 1'b0;
    mmio_rd_addr = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          latch   = 1'b1;
          ecfg_d  = 1'b0;
          etmo_d  = 1'b0;
          idx_d   = '0;
          state_d = ST_WR_CFG;
        end
      end
      ST_WR_CFG: begin
        mmio_wr_en   = 1'b1;
        mmio_wr_addr = cfg_reg_addr(idx_q);
        mmio_wr_data = cfg_val;
        if (idx_q == CFG_LAST) begin
          idx_d   = '0;
          state_d = ST_RD_ISSUE;
        end else begin
          idx_d = idx_q + 3'd1;
        end
      end
      ST_RD_ISSUE: begin
        mmio_rd_en   = 1'b1;
        mmio_rd_addr = cfg_reg_addr(idx_q);
        state_d      = ST_RD_CHK;
      end
      ST_RD_CHK: begin
        if (mmio_rd_data != cfg_val) begin
          ecfg_d  = 1'b1;
          state_d = ST_IDLE;
        end else if (idx_q == CFG_LAST) begin
          state_d = ST_GO;
        end else begin
          idx_d   = idx_q + 3'd1;
          state_d = ST_RD_ISSUE;
        end
      end
      ST_GO: begin
        mmio_wr_en   = 1'b1;
        mmio_wr_addr = REG_GO;
        mmio_wr_data = 64'd1;
        tmo_d        = '0;
        gap_d        = '0;
        state_d      = ST_POLL_WAIT;
      end
      ST_POLL_WAIT: begin
        tmo_d = tmo_q + 32'd1;
        if (tmo_hit) begin
          etmo_d  = 1'b1;
          state_d = ST_IDLE;
        end else if (gap_q == GAP_LAST) begin
          state_d = ST_POLL_RD;
        end else begin
          gap_d = gap_q + 8'd1;
        end
      end
      ST_POLL_RD: begin
        mmio_rd_en   = 1'b1;
        mmio_rd_addr = REG_STATUS;
        tmo_d        = tmo_q + 32'd1;
        if (tmo_hit) begin
          etmo_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_POLL_CHK;
        end
      end
      ST_POLL_CHK: begin
        tmo_d = tmo_q + 32'd1;
        // done wins over a timeout landing on the same cycle
        if (mmio_rd_data[0]) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else if (tmo_hit) begin
          etmo_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          gap_d   = '0;
          state_d = ST_POLL_WAIT;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      gap_q   <= '0;
      tmo_q   <= '0;
      rd_q    <= '0;
      wr_q    <= '0;
      ns_q    <= '0;
      cc_q    <= '0;
      sw_q    <= 1'b0;
      lim_q   <= '0;
      ecfg_q  <= 1'b0;
      etmo_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      gap_q   <= gap_d;
      tmo_q   <= tmo_d;
      ecfg_q  <= ecfg_d;
      etmo_q  <= etmo_d;
      done_q  <= done_d;
      if (latch) begin
        rd_q  <= cfg_rd_addr;
        wr_q  <= cfg_wr_addr;
        ns_q  <= cfg_num_samples;
        cc_q  <= cfg_collect_cycles;
        sw_q  <= cfg_switcher_en;
        lim_q <= cfg_timeout;
      end
    end
  end

  assign busy        = (state_q != ST_IDLE);
  assign run_done    = done_q;
  assign err_cfg     = ecfg_q;
  assign err_timeout = etmo_q;

endmodule

// File: tb/tb_mmio_run_ctrl.sv
// Self-checking bench for mmio_run_ctrl against
// a memory-map responder and a timing model.
module tb_mmio_run_ctrl;

  localparam int G      = 16;
  localparam int BUDGET = 3000;
  localparam int NEVER  = 1000000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [63:0] cfg_rd_addr = '0;
  logic [63:0] cfg_wr_addr = '0;
  logic [31:0] cfg_num_samples = '0;
  logic [31:0] cfg_collect_cycles = '0;
  logic        cfg_switcher_en = 1'b0;
  logic [31:0] cfg_timeout = '0;
  logic        mmio_wr_en;
  logic [15:0] mmio_wr_addr;
  logic [63:0] mmio_wr_data;
  logic        mmio_rd_en;
  logic [15:0] mmio_rd_addr;
  logic [63:0] rd_data = '0;
  logic        busy;
  logic        run_done;
  logic        err_cfg;
  logic        err_timeout;

  mmio_run_ctrl #(
    .ADDR_WIDTH(64),
    .SIZE_WIDTH(32),
    .POLL_GAP(G)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .start             (start),
    .cfg_rd_addr       (cfg_rd_addr),
    .cfg_wr_addr       (cfg_wr_addr),
    .cfg_num_samples   (cfg_num_samples),
    .cfg_collect_cycles(cfg_collect_cycles),
    .cfg_switcher_en   (cfg_switcher_en),
    .cfg_timeout       (cfg_timeout),
    .mmio_wr_en        (mmio_wr_en),
    .mmio_wr_addr      (mmio_wr_addr),
    .mmio_wr_data      (mmio_wr_data),
    .mmio_rd_en        (mmio_rd_en),
    .mmio_rd_addr      (mmio_rd_addr),
    .mmio_rd_data      (rd_data),
    .busy              (busy),
    .run_done          (run_done),
    .err_cfg           (err_cfg),
    .err_timeout       (err_timeout)
  );

  always #5 clk = ~clk;

  // Responder state shared with the stimulus.
  logic [63:0] mem [0:255];
  bit          go_seen;
  int          go_k;
  int          done_at;
  bit          fault54;

  always @(posedge clk) begin
    if (mmio_wr_en)
      mem[mmio_wr_addr[7:0]] <= mmio_wr_data;
    if (mmio_rd_en) begin
      if (mmio_rd_addr == 16'h0060)
        rd_data <= {63'd0, go_seen && (go_k >= done_at)};
      else if (fault54 && mmio_rd_addr == 16'h0054)
        rd_data <= '0;
      else
        rd_data <= mem[mmio_rd_addr[7:0]];
    end else begin
      rd_data <= 64'hA5A5_5A5A_DEAD_BEEF;
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h, expected %0h",
             tag, obs, exp);
    end
  endtask

  // Configuration under test (model copy).
  logic [63:0] c_rd, c_wr;
  logic [31:0] c_ns, c_cc, c_to;
  logic        c_sw;

  // Observations.
  logic [15:0] wa_q[$];
  logic [63:0] wd_q[$];
  logic [15:0] ra_q[$];
  int          done_pulses, viol, end_k, post;
  logic        e_busy, e_done, e_cfg, e_tmo;

  // Expectations.
  logic [15:0] exp_wa[$];
  logic [63:0] exp_wd[$];
  logic [15:0] exp_ra[$];
  int          exp_end;
  logic        exp_done, exp_tmo, exp_cfg;

  task automatic apply_cfg();
    cfg_rd_addr        = c_rd;
    cfg_wr_addr        = c_wr;
    cfg_num_samples    = c_ns;
    cfg_collect_cycles = c_cc;
    cfg_switcher_en    = c_sw;
    cfg_timeout        = c_to;
  endtask

  task automatic scramble_cfg();
    cfg_rd_addr        = {$urandom, $urandom};
    cfg_wr_addr        = {$urandom, $urandom};
    cfg_num_samples    = $urandom;
    cfg_collect_cycles = $urandom;
    cfg_switcher_en    = 1'($urandom_range(0, 1));
    cfg_timeout        = $urandom;
  endtask

  // Polls sample status every G+2 cycles after go;
  // the first sample seeing done decides, unless the
  // timeout count expires strictly earlier.
  task automatic build_exp(input bit fault);
    int m, s, polls, t;
    t = int'(c_to);
    exp_wa = '{16'h0052, 16'h0054, 16'h0056,
               16'h0058, 16'h0070};
    exp_wd = '{c_rd, c_wr, 64'(c_ns),
               64'(c_cc), 64'(c_sw)};
    exp_cfg = 1'b0;
    if (fault) begin
      exp_ra   = '{16'h0052, 16'h0054};
      exp_end  = -1;
      exp_done = 1'b0;
      exp_tmo  = 1'b0;
      exp_cfg  = 1'b1;
      return;
    end
    exp_ra = '{16'h0052, 16'h0054, 16'h0056,
               16'h0058, 16'h0070};
    exp_wa.push_back(16'h0050);
    exp_wd.push_back(64'd1);
    m = (done_at + G + 2) / (G + 2);
    s = m * (G + 2);
    if (t != 0 && t < s) begin
      exp_tmo  = 1'b1;
      exp_done = 1'b0;
      exp_end  = t + 1;
      polls    = (t + 1) / (G + 2);
    end else begin
      exp_tmo  = 1'b0;
      exp_done = 1'b1;
      exp_end  = s + 1;
      polls    = m;
    end
    repeat (polls) exp_ra.push_back(16'h0060);
  endtask

  task automatic sample_cycle();
    if (mmio_wr_en) begin
      wa_q.push_back(mmio_wr_addr);
      wd_q.push_back(mmio_wr_data);
    end
    if (mmio_rd_en)
      ra_q.push_back(mmio_rd_addr);
    if (mmio_wr_en && mmio_rd_en)
      viol++;
    if (!mmio_wr_en &&
        (mmio_wr_addr != '0 || mmio_wr_data != '0))
      viol++;
    if (!mmio_rd_en && mmio_rd_addr != '0)
      viol++;
    if (run_done)
      done_pulses++;
    if (mmio_wr_en && mmio_wr_addr == 16'h0050) begin
      go_seen = 1'b1;
      go_k    = 0;
    end else if (go_seen) begin
      go_k++;
    end
    if (!busy)
      end_k = go_seen ? go_k : -1;
  endtask

  // Called at #1 after an edge with the DUT idle.
  task automatic run_seq(input bit noise);
    int n;
    wa_q.delete();
    wd_q.delete();
    ra_q.delete();
    go_seen     = 1'b0;
    go_k        = 0;
    done_pulses = 0;
    viol        = 0;
    end_k       = -1;
    apply_cfg();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    n = 0;
    forever begin
      sample_cycle();
      if (!busy || n >= BUDGET) break;
      if (noise) begin
        start = ($urandom_range(0, 2) == 0);
        scramble_cfg();
      end
      @(posedge clk);
      #1;
      n++;
    end
    start  = 1'b0;
    e_busy = busy;
    e_done = run_done;
    e_cfg  = err_cfg;
    e_tmo  = err_timeout;
    post   = 0;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (mmio_wr_en || mmio_rd_en || busy || run_done)
        post++;
    end
  endtask

  task automatic check_run(input string tag);
    int nw, nr;
    chk({tag, "_ended"}, 64'(e_busy), 64'd0);
    chk({tag, "_wr_cnt"}, 64'(wa_q.size()),
        64'(exp_wa.size()));
    nw = (wa_q.size() < exp_wa.size()) ?
         wa_q.size() : exp_wa.size();
    for (int i = 0; i < nw; i++) begin
      chk($sformatf("%s_wa%0d", tag, i),
          64'(wa_q[i]), 64'(exp_wa[i]));
      chk($sformatf("%s_wd%0d", tag, i),
          wd_q[i], exp_wd[i]);
    end
    chk({tag, "_rd_cnt"}, 64'(ra_q.size()),
        64'(exp_ra.size()));
    nr = (ra_q.size() < exp_ra.size()) ?
         ra_q.size() : exp_ra.size();
    for (int i = 0; i < nr; i++)
      chk($sformatf("%s_ra%0d", tag, i),
          64'(ra_q[i]), 64'(exp_ra[i]));
    chk({tag, "_end_k"}, 64'(end_k), 64'(exp_end));
    chk({tag, "_run_done"}, 64'(e_done), 64'(exp_done));
    chk({tag, "_done_pulses"}, 64'(done_pulses),
        64'(exp_done));
    chk({tag, "_err_cfg"}, 64'(e_cfg), 64'(exp_cfg));
    chk({tag, "_err_tmo"}, 64'(e_tmo), 64'(exp_tmo));
    chk({tag, "_strobe_rules"}, 64'(viol), 64'd0);
    chk({tag, "_quiet_after"}, 64'(post), 64'd0);
  endtask

  task automatic nominal_cfg();
    c_rd = 64'h1000;
    c_wr = 64'h2000;
    c_ns = 32'd8;
    c_cc = 32'd100;
    c_sw = 1'b1;
    c_to = 32'd0;
  endtask

  initial begin
    int n;
    fault54 = 1'b0;
    done_at = NEVER;
    go_seen = 1'b0;
    go_k    = 0;

    repeat (2) @(posedge clk);
    #1;
    chk("reset_outs",
        64'(|{mmio_wr_en, mmio_wr_addr, mmio_wr_data,
              mmio_rd_en, mmio_rd_addr, busy, run_done,
              err_cfg, err_timeout}), 64'd0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("idle_busy", 64'(busy), 64'd0);

    nominal_cfg();
    done_at = 200;
    build_exp(1'b0);
    run_seq(1'b0);
    check_run("nominal");

    fault54 = 1'b1;
    build_exp(1'b1);
    run_seq(1'b0);
    check_run("rb_fault");
    fault54 = 1'b0;

    c_to    = 32'd50;
    done_at = NEVER;
    build_exp(1'b0);
    run_seq(1'b0);
    check_run("timeout");
    chk("timeout_bound",
        64'(end_k >= 1 && end_k <= 50 + G + 2), 64'd1);

    c_to    = 32'd18;
    done_at = 17;
    build_exp(1'b0);
    run_seq(1'b0);
    check_run("tie_done");

    c_to = 32'd17;
    build_exp(1'b0);
    run_seq(1'b0);
    check_run("tmo_edge");

    nominal_cfg();
    c_rd    = 64'hFEDC_BA98_7654_3210;
    c_cc    = 32'hFFFF_FFFF;
    done_at = 40;
    build_exp(1'b0);
    run_seq(1'b1);
    check_run("start_busy");

    for (int r = 0; r < 6; r++) begin
      c_rd = {$urandom, $urandom};
      c_wr = {$urandom, $urandom};
      c_ns = $urandom;
      c_cc = $urandom;
      c_sw = 1'($urandom_range(0, 1));
      c_to = ($urandom_range(0, 2) == 0) ? 32'd0 :
             32'($urandom_range(1, 100));
      done_at = $urandom_range(0, 90);
      build_exp(1'b0);
      run_seq(r[0]);
      check_run($sformatf("rand%0d", r));
    end

    nominal_cfg();
    done_at = NEVER;
    apply_cfg();
    go_seen = 1'b0;
    go_k    = 0;
    start   = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    n = 0;
    while (!(go_seen && go_k == 5) && n < 100) begin
      @(posedge clk);
      #1;
      n++;
      if (mmio_wr_en && mmio_wr_addr == 16'h0050) begin
        go_seen = 1'b1;
        go_k    = 0;
      end else if (go_seen) begin
        go_k++;
      end
    end
    chk("rst_in_poll", 64'(busy && go_seen), 64'd1);
    rst = 1'b0;
    #1;
    chk("rst_outs_now",
        64'(|{mmio_wr_en, mmio_wr_addr, mmio_wr_data,
              mmio_rd_en, mmio_rd_addr, busy, run_done,
              err_cfg, err_timeout}), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst  = 1'b1;
    post = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (mmio_wr_en || mmio_rd_en || busy || run_done)
        post++;
    end
    chk("rst_quiet", 64'(post), 64'd0);

    nominal_cfg();
    done_at = 30;
    build_exp(1'b0);
    run_seq(1'b0);
    check_run("after_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
